// File: rtl/alu_pkg.sv
// alu_pkg: constants and op codes shared by the ALU and the reservation station.
//   XLEN           datapath width
//   ROB_SIZE_WIDTH ROB tag width
//   ALU_OP_WIDTH   op code width
//   alu_op_e       op code encoding
package alu_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_SIZE_WIDTH = 3;
  localparam int ALU_OP_WIDTH   = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SHRA = 4'd7,
    ALU_EQ   = 4'd8,
    ALU_NEQ  = 4'd9,
    ALU_LT   = 4'd10,
    ALU_LTU  = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_e;

endpackage

// File: rtl/alu_compute.sv
// alu_compute: purely combinational op/operand -> result.
//   i_op    op code (alu_op_e encoding; 14 and 15 give zero)
//   i_val1  operand 1
//   i_val2  operand 2; only [4:0] is used as the shift amount
//   o_res   result; compares return 1 or 0
module alu_compute
  import alu_pkg::*;
(
  input  logic [ALU_OP_WIDTH-1:0] i_op,
  input  logic [XLEN-1:0]         i_val1,
  input  logic [XLEN-1:0]         i_val2,
  output logic [XLEN-1:0]         o_res
);

  logic [4:0] w_shamt;
  logic       w_lt_s;
  logic       w_lt_u;
  logic       w_eq;

  assign w_shamt = i_val2[4:0];
  assign w_lt_s  = $signed(i_val1) < $signed(i_val2);
  assign w_lt_u  = i_val1 < i_val2;
  assign w_eq    = i_val1 == i_val2;

  always_comb begin
    o_res = '0;
    case (alu_op_e'(i_op))
      ALU_ADD:  o_res = i_val1 + i_val2;
      ALU_SUB:  o_res = i_val1 - i_val2;
      ALU_AND:  o_res = i_val1 & i_val2;
      ALU_OR:   o_res = i_val1 | i_val2;
      ALU_XOR:  o_res = i_val1 ^ i_val2;
      ALU_SHL:  o_res = i_val1 << w_shamt;
      ALU_SHR:  o_res = i_val1 >> w_shamt;
      ALU_SHRA: o_res = $unsigned($signed(i_val1) >>> w_shamt);
      ALU_EQ:   o_res = {{(XLEN-1){1'b0}}, w_eq};
      ALU_NEQ:  o_res = {{(XLEN-1){1'b0}}, ~w_eq};
      ALU_LT:   o_res = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_LTU:  o_res = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_GE:   o_res = {{(XLEN-1){1'b0}}, ~w_lt_s};
      ALU_GEU:  o_res = {{(XLEN-1){1'b0}}, ~w_lt_u};
      default:  o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: two-stage pipelined integer execution unit.
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous kill of all in-flight work
//   rs_ready/op/val1/val2/id   issue from the reservation station (never stalled)
//   alu_ready/res/id           result broadcast, one-cycle pulse per op
//   alu_idle        no valid op in either stage
module alu
  import alu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      rs_ready,
  input  logic [ALU_OP_WIDTH-1:0]   rs_op,
  input  logic [XLEN-1:0]           rs_val1,
  input  logic [XLEN-1:0]           rs_val2,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_id,
  output logic                      alu_ready,
  output logic [XLEN-1:0]           alu_res,
  output logic [ROB_SIZE_WIDTH-1:0] alu_id,
  output logic                      alu_idle
);

  logic                      r_e1_valid;
  logic [ALU_OP_WIDTH-1:0]   r_e1_op;
  logic [XLEN-1:0]           r_e1_val1;
  logic [XLEN-1:0]           r_e1_val2;
  logic [ROB_SIZE_WIDTH-1:0] r_e1_id;

  logic                      r_e2_valid;
  logic [XLEN-1:0]           r_e2_res;
  logic [ROB_SIZE_WIDTH-1:0] r_e2_id;

  logic [XLEN-1:0]           w_res;

  // E1: an issue coinciding with flush is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e1_valid <= 1'b0;
      r_e1_op    <= '0;
      r_e1_val1  <= '0;
      r_e1_val2  <= '0;
      r_e1_id    <= '0;
    end else begin
      r_e1_valid <= rs_ready & ~flush;
      if (rs_ready && !flush) begin
        r_e1_op   <= rs_op;
        r_e1_val1 <= rs_val1;
        r_e1_val2 <= rs_val2;
        r_e1_id   <= rs_id;
      end
    end
  end

  alu_compute u_compute (
    .i_op   (r_e1_op),
    .i_val1 (r_e1_val1),
    .i_val2 (r_e1_val2),
    .o_res  (w_res)
  );

  // E2: result/tag only update on a surviving op so they hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e2_valid <= 1'b0;
      r_e2_res   <= '0;
      r_e2_id    <= '0;
    end else begin
      r_e2_valid <= r_e1_valid & ~flush;
      if (r_e1_valid && !flush) begin
        r_e2_res <= w_res;
        r_e2_id  <= r_e1_id;
      end
    end
  end

  assign alu_ready = r_e2_valid;
  assign alu_res   = r_e2_res;
  assign alu_id    = r_e2_id;
  assign alu_idle  = ~r_e1_valid & ~r_e2_valid;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        rs_ready;
  logic [3:0]  rs_op;
  logic [31:0] rs_val1;
  logic [31:0] rs_val2;
  logic [2:0]  rs_id;
  logic        alu_ready;
  logic [31:0] alu_res;
  logic [2:0]  alu_id;
  logic        alu_idle;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .rs_ready  (rs_ready),
    .rs_op     (rs_op),
    .rs_val1   (rs_val1),
    .rs_val2   (rs_val2),
    .rs_id     (rs_id),
    .alu_ready (alu_ready),
    .alu_res   (alu_res),
    .alu_id    (alu_id),
    .alu_idle  (alu_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  id;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic        exp_ready = 1'b0;
  logic [31:0] exp_res = '0;
  logic [2:0]  exp_id = '0;

  // Reference semantics written directly from the op table.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = b % 32;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return (a != b) ? 32'd1 : 32'd0;
      4'd10: return (sa < sb) ? 32'd1 : 32'd0;
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd12: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd13: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model();
    logic exp_idle;
    exp_idle = (q.size() == 0) && !exp_ready;
    chk("ready", {31'b0, alu_ready}, {31'b0, exp_ready});
    chk("res",   alu_res, exp_res);
    chk("id",    {29'b0, alu_id}, {29'b0, exp_id});
    chk("idle",  {31'b0, alu_idle}, {31'b0, exp_idle});
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, check.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] id, input logic fl);
    rs_ready = v;
    rs_op    = op;
    rs_val1  = a;
    rs_val2  = b;
    rs_id    = id;
    flush    = fl;
    @(posedge clk);
    cyc++;
    exp_ready = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc - 1) begin
      if (!fl) begin
        exp_ready = 1'b1;
        exp_res   = q[0].res;
        exp_id    = q[0].id;
      end
      void'(q.pop_front());
    end
    if (v && !fl) q.push_back('{res: ref_op(op, a, b), id: id, cyc: cyc});
    #1;
    check_model();
  endtask

  task automatic idle_step();
    step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic [2:0] id);
    chk({tag, "_ready"}, {31'b0, alu_ready}, 32'd1);
    chk({tag, "_res"}, alu_res, res);
    chk({tag, "_id"}, {29'b0, alu_id}, {29'b0, id});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 40));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
      default: return {1'b1, 31'($urandom)};
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; rs_ready = 1'b0;
    rs_op = '0; rs_val1 = '0; rs_val2 = '0; rs_id = '0;
    repeat (2) @(posedge clk);
    #1;
    check_model();
    #2 rst = 1'b0;

    // ADD wrap, exactly two edges of latency
    step(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0);
    chk("add_not_yet", {31'b0, alu_ready}, 32'd0);
    idle_step();
    expect_out("add_wrap", 32'h0, 3'd5);

    step(1'b1, 4'd1, 32'd0, 32'd1, 3'd1, 1'b0);
    idle_step();
    expect_out("sub_wrap", 32'hFFFF_FFFF, 3'd1);

    step(1'b1, 4'd7, 32'h8000_0000, 32'h21, 3'd2, 1'b0);
    step(1'b1, 4'd6, 32'h8000_0000, 32'h21, 3'd3, 1'b0);
    expect_out("shra", 32'hC000_0000, 3'd2);
    step(1'b1, 4'd5, 32'd1, 32'd31, 3'd4, 1'b0);
    expect_out("shr", 32'h4000_0000, 3'd3);
    step(1'b1, 4'd10, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0);
    expect_out("shl", 32'h8000_0000, 3'd4);
    step(1'b1, 4'd11, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0);
    expect_out("lt", 32'd1, 3'd5);
    step(1'b1, 4'd13, 32'd5, 32'd5, 3'd7, 1'b0);
    expect_out("ltu", 32'd0, 3'd6);
    step(1'b1, 4'd9, 32'd3, 32'd3, 3'd0, 1'b0);
    expect_out("geu", 32'd1, 3'd7);
    step(1'b1, 4'd15, 32'h1234, 32'h5678, 3'd1, 1'b0);
    expect_out("neq", 32'd0, 3'd0);
    step(1'b1, 4'd0, 32'd7, 32'd8, 3'd2, 1'b0);
    expect_out("op15", 32'd0, 3'd1);
    idle_step();
    expect_out("add_after_op15", 32'd15, 3'd2);
    idle_step();
    chk("held_res", alu_res, 32'd15);
    chk("held_id", {29'b0, alu_id}, 32'd2);

    // back-to-back pipelining
    step(1'b1, 4'd0, 32'd10, 32'd1, 3'd1, 1'b0);
    step(1'b1, 4'd0, 32'd20, 32'd2, 3'd2, 1'b0);
    expect_out("pipe1", 32'd11, 3'd1);
    step(1'b1, 4'd0, 32'd30, 32'd3, 3'd3, 1'b0);
    expect_out("pipe2", 32'd22, 3'd2);
    chk("pipe_idle", {31'b0, alu_idle}, 32'd0);
    idle_step();
    expect_out("pipe3", 32'd33, 3'd3);
    idle_step();

    // flush: tag 4 already broadcast, tag 5 in E1 killed, tag 6 dropped
    step(1'b1, 4'd2, 32'hF0F0, 32'hFF00, 3'd4, 1'b0);
    step(1'b1, 4'd3, 32'h1, 32'h2, 3'd5, 1'b0);
    expect_out("flush_t4", 32'hF000, 3'd4);
    step(1'b1, 4'd4, 32'h3, 32'h5, 3'd6, 1'b1);
    chk("flush_ready", {31'b0, alu_ready}, 32'd0);
    chk("flush_idle", {31'b0, alu_idle}, 32'd1);
    idle_step();
    chk("flush_no_pulse", {31'b0, alu_ready}, 32'd0);

    // async reset mid-cycle with an op in E1
    step(1'b1, 4'd0, 32'd100, 32'd1, 3'd3, 1'b0);
    step(1'b1, 4'd0, 32'd200, 32'd2, 3'd7, 1'b0);
    rs_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    exp_ready = 1'b0; exp_res = '0; exp_id = '0;
    chk("rst_ready", {31'b0, alu_ready}, 32'd0);
    chk("rst_res", alu_res, 32'd0);
    chk("rst_id", {29'b0, alu_id}, 32'd0);
    chk("rst_idle", {31'b0, alu_idle}, 32'd1);
    @(posedge clk);
    cyc++;
    #3 rst = 1'b0;
    step(1'b1, 4'd1, 32'd50, 32'd8, 3'd6, 1'b0);
    idle_step();
    expect_out("post_rst", 32'd42, 3'd6);
    idle_step();

    // randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), pick(), pick(),
           3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end
    repeat (3) idle_step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
